// File: rtl/serial_binary_subtractor_pkg.sv
// Shared types and the single-bit subtract primitive for the serial subtractor.
package sub_pkg;

    // Controller states: waiting, shifting one bit per clock, result presented.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One full-subtractor step: returns {difference bit, borrow out}.
    function automatic logic [1:0] full_sub(input logic x, input logic y, input logic br);
        logic d;
        logic bo;
        d  = x ^ y ^ br;
        bo = (~x & y) | (~(x ^ y) & br);
        return {d, bo};
    endfunction

endpackage

// File: rtl/serial_binary_subtractor_if.sv
// Start/busy/done handshake plus operand and result buses of the serial subtractor.
interface serial_binary_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    // Requester side: issues operands and start, observes status and result.
    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    // Subtractor side.
    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_binary_subtractor_full_subtractor.sv
// Purely combinational one-bit full subtractor: d = x - y - bi, bo = borrow out.
module full_subtractor
    import sub_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    // The package function is the single definition of the bit-level rule.
    assign {d, bo} = full_sub(x, y, bi);

endmodule

// File: rtl/serial_binary_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, LSB first, one bit per clock.
// Operands are captured on an accepted start; result registers only update on entry
// to DONE so the outputs never expose a partially built difference.
module serial_binary_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    serial_binary_subtractor_if.slave bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    // The partial register only needs the first WIDTH-1 result bits; the last bit
    // goes straight from the cell into the output register.
    localparam int PW    = (WIDTH > 1) ? WIDTH - 1 : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic             br_q;
    logic [PW-1:0]    res_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             busy_q;
    logic             done_q;

    logic             d_bit;
    logic             bo_bit;
    logic [PW-1:0]    res_d;
    logic [WIDTH-1:0] diff_d;

    full_subtractor u_fs (
        .x  (sa_q[0]),
        .y  (sb_q[0]),
        .bi (br_q),
        .d  (d_bit),
        .bo (bo_bit)
    );

    // New difference bit enters at the MSB of the partial result, so after the last
    // shift the bits sit in their natural order below the final bit.
    generate
        if (WIDTH == 1) begin : g_w1
            assign res_d  = res_q;
            assign diff_d = d_bit;
        end else if (WIDTH == 2) begin : g_w2
            assign res_d  = d_bit;
            assign diff_d = {d_bit, res_q};
        end else begin : g_wn
            assign res_d  = {d_bit, res_q[PW-1:1]};
            assign diff_d = {d_bit, res_q};
        end
    endgenerate

    // Controller, counter, operand shifters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
            br_q    <= 1'b0;
            res_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state_q <= SHIFT;
                        busy_q  <= 1'b1;
                        sa_q    <= bus.a;
                        sb_q    <= bus.b;
                        br_q    <= bus.bin;
                        cnt_q   <= '0;
                        res_q   <= '0;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                SHIFT: begin
                    sa_q  <= sa_q >> 1;
                    sb_q  <= sb_q >> 1;
                    br_q  <= bo_bit;
                    res_q <= res_d;
                    if (cnt_q == LAST_CNT) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        diff_q  <= diff_d;
                        bout_q  <= bo_bit;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_binary_subtractor.sv
// Self-checking bench for serial_binary_subtractor (WIDTH=4): directed vectors with
// literal expectations plus a cycle-level behavioural model checked every cycle.
module tb_serial_binary_subtractor;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    serial_binary_subtractor_if #(.WIDTH(W)) bus ();

    serial_binary_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an accepted request makes the unit busy for W cycles, then
    // presents the arithmetic result for one done cycle; results hold until replaced.
    int           m_left = 0;
    logic [W:0]   m_res  = '0;
    logic         e_done = 1'b0;
    logic [W-1:0] e_diff = '0;
    logic         e_bout = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0;
            e_done = 1'b0;
            e_diff = '0;
            e_bout = 1'b0;
        end else begin
            e_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    e_done = 1'b1;
                    e_diff = m_res[W-1:0];
                    e_bout = m_res[W];
                end
            end else if (bus.start) begin
                m_left = W;
                m_res  = {1'b0, bus.a} - {1'b0, bus.b} - {{W{1'b0}}, bus.bin};
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model busy", {31'd0, bus.busy}, {31'd0, (m_left > 0)});
            chk("model done", {31'd0, bus.done}, {31'd0, e_done});
            chk("model diff", {28'd0, bus.diff}, {28'd0, e_diff});
            chk("model bout", {31'd0, bus.bout}, {31'd0, e_bout});
        end
    end

    // Issue one request at the current negedge and wait (bounded) for its done pulse.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                          input logic [W-1:0] xd, input logic xb, input string tag);
        int k;
        bus.a     = ta;
        bus.b     = tb_v;
        bus.bin   = tbin;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        k = 1;
        while (bus.done !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " latency"}, k, W + 1);
        chk({tag, " diff"}, {28'd0, bus.diff}, {28'd0, xd});
        chk({tag, " bout"}, {31'd0, bus.bout}, {31'd0, xb});
        $display("op %s: a=%0d b=%0d bin=%0d -> diff=%0d bout=%0d (cycles=%0d)",
                 tag, ta, tb_v, tbin, bus.diff, bus.bout, k);
    endtask

    initial begin
        int k;
        int p;
        logic [W-1:0] sa, sb;
        logic sbin;
        logic [W:0] xr;

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset busy", {31'd0, bus.busy}, 32'd0);
        chk("reset done", {31'd0, bus.done}, 32'd0);
        chk("reset diff", {28'd0, bus.diff}, 32'd0);
        chk("reset bout", {31'd0, bus.bout}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors with hand-computed results; consecutive calls run back-to-back.
        run_op(4'd9,  4'd5,  1'b0, 4'd4,  1'b0, "9-5");
        run_op(4'd8,  4'd1,  1'b0, 4'd7,  1'b0, "8-1 b2b");
        run_op(4'd3,  4'd7,  1'b0, 4'd12, 1'b1, "3-7");
        run_op(4'd0,  4'd0,  1'b1, 4'd15, 1'b1, "0-0-1");
        run_op(4'd15, 4'd15, 1'b1, 4'd15, 1'b1, "15-15-1");
        run_op(4'd0,  4'd1,  1'b0, 4'd15, 1'b1, "0-1");
        @(negedge clk);
        @(negedge clk);

        // Start during SHIFT with other operands must be ignored.
        bus.a = 4'd6; bus.b = 4'd2; bus.bin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.a = 4'd1; bus.b = 4'd5; bus.bin = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        k = 3;
        while (bus.done !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("ignored start latency", k, W + 1);
        chk("ignored start diff", {28'd0, bus.diff}, 32'd4);
        chk("ignored start bout", {31'd0, bus.bout}, 32'd0);
        $display("op 6-2 with mid-shift start: diff=%0d bout=%0d (cycles=%0d)", bus.diff, bus.bout, k);
        @(negedge clk);
        @(negedge clk);

        // Reset at the second SHIFT cycle aborts with no done pulse.
        bus.a = 4'd13; bus.b = 4'd2; bus.bin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", {31'd0, bus.busy}, 32'd0);
        chk("abort done", {31'd0, bus.done}, 32'd0);
        chk("abort diff", {28'd0, bus.diff}, 32'd0);
        chk("abort bout", {31'd0, bus.bout}, 32'd0);
        $display("op 13-2 aborted by reset: busy=%0d done=%0d diff=%0d", bus.busy, bus.done, bus.diff);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort no done", {31'd0, bus.done}, 32'd0);
        end

        // Sweep of every (a,b,bin) combination in a scrambled order.
        for (int idx = 0; idx < 512; idx++) begin
            p    = (idx * 167) % 512;
            sa   = p[8:5];
            sb   = p[4:1];
            sbin = p[0];
            xr   = {1'b0, sa} - {1'b0, sb} - {{W{1'b0}}, sbin};
            run_op(sa, sb, sbin, xr[W-1:0], xr[W], "sweep");
        end
        @(negedge clk);
        @(negedge clk);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
